// File: rtl/ps2_keycode_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefix sequences into single key
// events and presents them through a one-entry valid/ready register.
module ps2_keycode_decoder #(
    parameter bit         DROP_FAKE_SHIFT = 1'b1,
    parameter logic [7:0] PAUSE_CODE      = 8'h77
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] key_code_o,
    output logic       extended_o,
    output logic       break_o,
    output logic       event_valid_o,
    input  logic       event_ready_i,
    output logic       overflow_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;

    // Device responses (self-test, echo, ack, resend, errors) that carry no key.
    function automatic logic is_response(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        logic r;
        case (b)
            8'h12, 8'h59: r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic [2:0] cnt_r;
    logic [2:0] next_cnt_s;
    logic       ext_s;
    logic       brk_s;
    logic       emit_s;
    logic [7:0] emit_code_s;
    logic       emit_ext_s;
    logic       emit_brk_s;

    assign ext_s = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
    assign brk_s = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);

    // Prefix decoding: next state, pause byte counter and event generation.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        emit_s       = 1'b0;
        emit_code_s  = 8'h00;
        emit_ext_s   = 1'b0;
        emit_brk_s   = 1'b0;
        if (valid_i) begin
            if (state_r == ST_PAUSE) begin
                next_cnt_s = cnt_r - 3'd1;
                // A zero count here can only come from corruption; finish the sequence.
                if (cnt_r <= 3'd1) begin
                    next_cnt_s   = 3'd0;
                    next_state_s = ST_IDLE;
                    emit_s       = 1'b1;
                    emit_code_s  = PAUSE_CODE;
                    emit_ext_s   = 1'b1;
                    emit_brk_s   = 1'b0;
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end else begin
                case (data_i)
                    8'hE1: begin
                        next_state_s = ST_PAUSE;
                        next_cnt_s   = 3'd7;
                    end
                    8'hE0: next_state_s = ST_EXT;
                    8'hF0: next_state_s = ext_s ? ST_EXT_BRK : ST_BRK;
                    default: begin
                        if ((state_r == ST_IDLE) && is_response(data_i)) begin
                            next_state_s = ST_IDLE;
                        end else if (DROP_FAKE_SHIFT && ext_s && is_fake_shift(data_i)) begin
                            next_state_s = ST_IDLE;
                        end else begin
                            next_state_s = ST_IDLE;
                            emit_s       = 1'b1;
                            emit_code_s  = data_i;
                            emit_ext_s   = ext_s;
                            emit_brk_s   = brk_s;
                        end
                    end
                endcase
            end
        end else begin
            next_state_s = state_r;
        end
    end

    // Decoder state and pause counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // One-entry output register; a full register drops new events and flags overflow.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            key_code_o    <= 8'h00;
            extended_o    <= 1'b0;
            break_o       <= 1'b0;
            event_valid_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else if (emit_s) begin
            if (!event_valid_o || event_ready_i) begin
                key_code_o    <= emit_code_s;
                extended_o    <= emit_ext_s;
                break_o       <= emit_brk_s;
                event_valid_o <= 1'b1;
            end else begin
                overflow_o <= 1'b1;
            end
        end else if (event_ready_i) begin
            event_valid_o <= 1'b0;
        end else begin
            event_valid_o <= event_valid_o;
        end
    end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder: byte sequences with hand-computed events.
module tb_ps2_keycode_decoder;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_code_o;
    logic       extended_o;
    logic       break_o;
    logic       event_valid_o;
    logic       event_ready_i;
    logic       overflow_o;

    int checks   = 0;
    int failures = 0;

    ps2_keycode_decoder #(
        .DROP_FAKE_SHIFT (1'b1),
        .PAUSE_CODE      (8'h77)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .key_code_o    (key_code_o),
        .extended_o    (extended_o),
        .break_o       (break_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full snapshot: {code, ext, brk, valid, overflow}.
    task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext,
                             input logic brk, input logic ovf);
        check(tag, {key_code_o, extended_o, break_o, event_valid_o, overflow_o},
              {code, ext, brk, 1'b1, ovf});
    endtask

    task automatic expect_none(input string tag, input logic ovf);
        check(tag, {8'h00, 2'b00, event_valid_o, overflow_o}, {8'h00, 2'b00, 1'b0, ovf});
    endtask

    // Present one byte for one clock; returns at the falling edge after it was sampled.
    task automatic send(input logic [7:0] b);
        @(negedge clk_i);
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    initial begin
        reset_i       = 1'b1;
        data_i        = 8'h00;
        valid_i       = 1'b0;
        event_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_state", {key_code_o, extended_o, break_o, event_valid_o, overflow_o}, 12'h000);
        reset_i = 1'b0;

        send(8'h1C); expect_ev("make_1c", 8'h1C, 1'b0, 1'b0, 1'b0);
        send(8'hF0); expect_none("brk_prefix", 1'b0);
        send(8'h1C); expect_ev("break_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i); expect_none("consumed", 1'b0);

        send(8'hE0); expect_none("ext_prefix", 1'b0);
        send(8'h75); expect_ev("ext_make_75", 8'h75, 1'b1, 1'b0, 1'b0);
        send(8'hE0); send(8'hF0); expect_none("ext_brk_prefix", 1'b0);
        send(8'h75); expect_ev("ext_break_75", 8'h75, 1'b1, 1'b1, 1'b0);

        send(8'hE0); send(8'h12); expect_none("fake_shift_12", 1'b0);
        send(8'hE0); send(8'h75); expect_ev("after_fake_shift", 8'h75, 1'b1, 1'b0, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h59); expect_none("fake_shift_brk_59", 1'b0);
        send(8'hF0); send(8'hE0); send(8'h75); expect_ev("e0_restarts_prefix", 8'h75, 1'b1, 1'b0, 1'b0);

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); expect_none("pause_7_bytes", 1'b0);
        send(8'h77); expect_ev("pause_event", 8'h77, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i); expect_none("pause_single", 1'b0);
        send(8'h1C); expect_ev("after_pause", 8'h1C, 1'b0, 1'b0, 1'b0);

        send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE); expect_none("responses_dropped", 1'b0);
        send(8'hF0); send(8'hAA); expect_ev("break_aa", 8'hAA, 1'b0, 1'b1, 1'b0);

        @(negedge clk_i);
        event_ready_i = 1'b0;
        send(8'h1C); expect_ev("held_1c", 8'h1C, 1'b0, 1'b0, 1'b0);
        send(8'h32); expect_ev("overflow_keeps_1c", 8'h1C, 1'b0, 1'b0, 1'b1);
        event_ready_i = 1'b1;
        @(negedge clk_i); expect_none("ready_consumes", 1'b1);
        event_ready_i = 1'b0;
        send(8'h1C); expect_ev("held_again", 8'h1C, 1'b0, 1'b0, 1'b1);
        data_i        = 8'h32;
        valid_i       = 1'b1;
        event_ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        expect_ev("emit_on_handshake", 8'h32, 1'b0, 1'b0, 1'b1);

        send(8'hE0); send(8'hF0);
        #3 reset_i = 1'b1;
        #1 check("async_reset", {key_code_o, extended_o, break_o, event_valid_o, overflow_o}, 12'h000);
        @(negedge clk_i);
        reset_i = 1'b0;
        send(8'h1C); expect_ev("after_abort", 8'h1C, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
